// File: rtl/weight_skew_feeder.sv
// Sequences NUM row reads from weight_buffer and skews the returned lanes
// so that lane i reaches the systolic array i cycles after lane 0.
module weight_skew_feeder #(
    parameter int LANES = 16,
    parameter int DW    = 32,
    parameter int AW    = 13
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW:0]         num_rows,
    input  logic                opstage,
    output logic                wb_cen,
    output logic                wb_wen,
    output logic                wb_opstage,
    output logic [AW-1:0]       wb_a,
    input  logic [LANES*DW-1:0] wb_q,
    output logic [LANES*DW-1:0] w_out,
    output logic [LANES-1:0]    w_valid,
    output logic                busy,
    output logic                done
);

    // state | meaning
    // IDLE  | waiting for start, outputs quiescent
    // READ  | one buffer row read per cycle
    // DRAIN | reads finished, waiting for the skew pipeline to empty
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t         state;
    logic [AW:0]    rows_left;
    logic           rd_v;
    logic [LANES-1:0] vld;
    logic           drain_empty;

    assign wb_wen  = 1'b1;
    assign w_valid = vld;

    // Empty on the next cycle: nothing entering lane 0 and only lane LANES-1 may still be valid.
    assign drain_empty = !rd_v && (vld[LANES-2:0] == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            rows_left  <= '0;
            rd_v       <= 1'b0;
            wb_cen     <= 1'b1;
            wb_opstage <= 1'b0;
            wb_a       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_v <= (state == READ);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        wb_a       <= base_addr;
                        rows_left  <= num_rows;
                        wb_opstage <= opstage;
                        busy       <= 1'b1;
                        if (num_rows != '0) begin
                            state  <= READ;
                            wb_cen <= 1'b0;
                        end else begin
                            state  <= DRAIN;
                        end
                    end
                end
                READ: begin
                    if (rows_left == (AW+1)'(1)) begin
                        wb_cen <= 1'b1;
                        state  <= DRAIN;
                    end else begin
                        wb_a      <= wb_a + 1'b1;
                        rows_left <= rows_left - 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        wb_opstage <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) vld <= '0;
        else     vld <= {vld[LANES-2:0], rd_v};
    end

    // Lane i is a delay line of i+1 registers; invalid slots carry zero.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DW-1:0] dly [0:i];

        always_ff @(posedge CLK) begin
            if (RST) begin
                for (int j = 0; j <= i; j++) dly[j] <= '0;
            end else begin
                dly[0] <= rd_v ? wb_q[i*DW +: DW] : '0;
                for (int j = 1; j <= i; j++) dly[j] <= dly[j-1];
            end
        end

        assign w_out[i*DW +: DW] = dly[i];
    end

endmodule

// File: tb/tb_weight_skew_feeder.sv
// Directed bench for weight_skew_feeder with a behavioural weight_buffer model.
module tb_weight_skew_feeder;
    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int AW    = 13;
    localparam int W     = LANES*DW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_rows;
    logic          opstage;
    logic          wb_cen, wb_wen, wb_opstage;
    logic [AW-1:0] wb_a;
    logic [W-1:0]  wb_q = '0;
    logic [W-1:0]  w_out;
    logic [LANES-1:0] w_valid;
    logic          busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    weight_skew_feeder #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .opstage(opstage), .wb_cen(wb_cen), .wb_wen(wb_wen),
        .wb_opstage(wb_opstage), .wb_a(wb_a), .wb_q(wb_q), .w_out(w_out),
        .w_valid(w_valid), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Buffer model: row r lane i = r*16+i, or 1.0 everywhere when OPSTAGE=0.
    always @(posedge CLK) begin
        if (!wb_cen) begin
            for (int i = 0; i < LANES; i++)
                wb_q[i*DW +: DW] <= wb_opstage ? (32'(wb_a) * 32'd16 + 32'(i)) : 32'h3F80_0000;
        end
    end

    task automatic check_idle(input string tag);
        n_tests++; if (wb_cen !== 1'b1) begin n_fail++; $display("FAIL %s wb_cen got %b exp 1", tag, wb_cen); end
        n_tests++; if (wb_wen !== 1'b1) begin n_fail++; $display("FAIL %s wb_wen got %b exp 1", tag, wb_wen); end
        n_tests++; if (wb_opstage !== 1'b0) begin n_fail++; $display("FAIL %s wb_opstage got %b exp 0", tag, wb_opstage); end
        n_tests++; if (wb_a !== '0) begin n_fail++; $display("FAIL %s wb_a got %0d exp 0", tag, wb_a); end
        n_tests++; if (w_out !== '0) begin n_fail++; $display("FAIL %s w_out got %h exp 0", tag, w_out); end
        n_tests++; if (w_valid !== '0) begin n_fail++; $display("FAIL %s w_valid got %h exp 0", tag, w_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy got %b exp 0", tag, busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done got %b exp 0", tag, done); end
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; opstage = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_idle($sformatf("reset_c%0d", c));
            @(posedge CLK); #1;
        end
    endtask

    // Cycle k is k cycles after the start cycle s. inj_k>0 pulses a conflicting start in cycle k.
    task automatic run_stream(input string tag, input int base, input int num, input bit op, input int inj_k);
        int done_k;
        int r;
        bit exp_busy;
        logic [W-1:0] exp_w;
        logic [LANES-1:0] exp_v;
        logic exp_cen;
        logic [AW-1:0] exp_a;
        done_k = (num == 0) ? 2 : num + 2 + LANES;
        @(posedge CLK); #1;
        base_addr = AW'(base); num_rows = (AW+1)'(num); opstage = op; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int k = 1; k <= done_k + 4; k++) begin
            exp_cen  = (k <= num) ? 1'b0 : 1'b1;
            exp_busy = (k < done_k);
            exp_w = '0; exp_v = '0;
            for (int i = 0; i < LANES; i++) begin
                r = k - 3 - i;
                if (r >= 0 && r < num) begin
                    exp_v[i] = 1'b1;
                    exp_w[i*DW +: DW] = op ? 32'(((base + r) % 8192) * 16 + i) : 32'h3F80_0000;
                end
            end
            n_tests++; if (wb_cen !== exp_cen) begin n_fail++; $display("FAIL %s k%0d wb_cen got %b exp %b", tag, k, wb_cen, exp_cen); end
            n_tests++; if (wb_wen !== 1'b1) begin n_fail++; $display("FAIL %s k%0d wb_wen got %b exp 1", tag, k, wb_wen); end
            if (exp_cen == 1'b0) begin
                exp_a = AW'((base + k - 1) % 8192);
                n_tests++; if (wb_a !== exp_a) begin n_fail++; $display("FAIL %s k%0d wb_a got %0d exp %0d", tag, k, wb_a, exp_a); end
            end
            n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL %s k%0d busy got %b exp %b", tag, k, busy, exp_busy); end
            n_tests++; if (done !== (k == done_k)) begin n_fail++; $display("FAIL %s k%0d done got %b exp %b", tag, k, done, (k == done_k)); end
            n_tests++; if (wb_opstage !== (exp_busy & op)) begin n_fail++; $display("FAIL %s k%0d wb_opstage got %b exp %b", tag, k, wb_opstage, exp_busy & op); end
            n_tests++; if (w_valid !== exp_v) begin n_fail++; $display("FAIL %s k%0d w_valid got %h exp %h", tag, k, w_valid, exp_v); end
            n_tests++; if (w_out !== exp_w) begin n_fail++; $display("FAIL %s k%0d w_out got %h exp %h", tag, k, w_out, exp_w); end
            if (k == inj_k) begin
                start = 1'b1; base_addr = 13'd100; num_rows = 14'd7; opstage = ~op;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_stream();      run_stream("stream",   0,    4, 1'b1, 0);  endtask
    task automatic test_const_one();   run_stream("const1",   20,   2, 1'b0, 20); endtask
    task automatic test_addr_wrap();   run_stream("wrap",     8191, 3, 1'b1, 0);  endtask
    task automatic test_zero_rows();   run_stream("zero",     7,    0, 1'b1, 1);  endtask
    task automatic test_busy_ignore(); run_stream("busy_ign", 5,    2, 1'b1, 3);  endtask

    task automatic test_abort();
        @(posedge CLK); #1;
        base_addr = '0; num_rows = 14'd10; opstage = 1'b1; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check_idle("abort");
        for (int c = 0; c < 30; c++) begin
            n_tests++; if (done !== 1'b0 || wb_cen !== 1'b1) begin
                n_fail++; $display("FAIL abort_quiet c%0d done got %b cen got %b exp 0/1", c, done, wb_cen);
            end
            @(posedge CLK); #1;
        end
        run_stream("after_abort", 0, 4, 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_const_one();
        test_addr_wrap();
        test_zero_rows();
        test_busy_ignore();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
